// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32 immediate generator with PC-relative target and skid buffer
//
// Decodes the I/S/B/U/J immediate, sign-extends it to DATA_WIDTH, adds it to
// pc, and holds results in a main/skid register pair behind valid/ready.

module imm_gen_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [DATA_WIDTH-1:0]  pc,
  input  logic [2:0]             ImmSrc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  ImmOp,
  output logic [DATA_WIDTH-1:0]  target,
  output logic                   illegal
);

  generate
    if (INSTR_WIDTH != 32) begin : g_bad_instr_width
      $error("imm_gen_pipe: INSTR_WIDTH must be 32");
    end
    if (DATA_WIDTH < 32) begin : g_bad_data_width
      $error("imm_gen_pipe: DATA_WIDTH must be >= 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state;
  logic [31:0]             imm32;
  logic                    new_ill;
  logic [DATA_WIDTH-1:0]   new_imm;
  logic [DATA_WIDTH-1:0]   new_tgt;
  logic [DATA_WIDTH-1:0]   skid_imm;
  logic [DATA_WIDTH-1:0]   skid_tgt;
  logic                    skid_ill;
  logic                    accept;
  logic                    drain;
  logic                    unused_opcode;

  // Opcode bits carry no immediate information in any format.
  assign unused_opcode = ^instr[6:0];

  // Assemble the 32-bit immediate for the selected format; illegal formats yield zero.
  always_comb begin
    imm32   = '0;
    new_ill = 1'b0;
    case (ImmSrc)
      3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011:  imm32 = {instr[31:12], 12'b0};
      3'b100:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: new_ill = 1'b1;
    endcase
  end

  // Replication count is at least one, so DATA_WIDTH == 32 needs no special case.
  assign new_imm = {{(DATA_WIDTH - 31){imm32[31]}}, imm32[30:0]};
  assign new_tgt = pc + new_imm;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Skid-buffer FSM: main register drives the outputs, skid catches one entry during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      ImmOp     <= '0;
      target    <= '0;
      illegal   <= 1'b0;
      skid_imm  <= '0;
      skid_tgt  <= '0;
      skid_ill  <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            ImmOp     <= new_imm;
            target    <= new_tgt;
            illegal   <= new_ill;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            ImmOp   <= new_imm;
            target  <= new_tgt;
            illegal <= new_ill;
          end else if (accept) begin
            skid_imm <= new_imm;
            skid_tgt <= new_tgt;
            skid_ill <= new_ill;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            ImmOp    <= skid_imm;
            target   <= skid_tgt;
            illegal  <= skid_ill;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (32- and 64-bit instances)

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr, pc;
  logic [2:0]  src;
  logic        in_ready, out_valid, illegal;
  logic [31:0] imm_op, tgt;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm_op64, tgt64, pc64;

  int n_checks = 0;
  int n_err    = 0;
  int n_pop    = 0;
  logic held   = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  src;
  } entry_t;

  entry_t q[$];

  always #5 clk = ~clk;

  assign pc64 = {32'h0, pc};

  imm_gen_pipe #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .ImmSrc(src),
    .out_valid(out_valid), .out_ready(out_ready),
    .ImmOp(imm_op), .target(tgt), .illegal(illegal)
  );

  imm_gen_pipe #(.DATA_WIDTH(64), .INSTR_WIDTH(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .pc(pc64), .ImmSrc(src),
    .out_valid(out_valid64), .out_ready(out_ready),
    .ImmOp(imm_op64), .target(tgt64), .illegal(illegal64)
  );

  // Immediate value as a signed integer, built arithmetically from field positions.
  function automatic longint ref_imm(logic [31:0] ins, logic [2:0] s);
    longint u, v, one;
    int w;
    u = ins;
    one = 1;
    case (s)
      3'd0: begin v = u >> 20; w = 12; end
      3'd1: begin v = ((u >> 25) << 5) | ((u >> 7) & 31); w = 12; end
      3'd2: begin
        v = ((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
        w = 13;
      end
      3'd3: begin v = (u >> 12) << 12; w = 32; end
      3'd4: begin
        v = ((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
        w = 21;
      end
      default: return 0;
    endcase
    if (v >= (one << (w - 1))) v = v - (one << w);
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check occupancy and delivered data at negedge, update the model, advance.
  task automatic cycle();
    entry_t      e;
    longint      v;
    logic [63:0] t64;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    if (out_valid && out_ready && q.size() != 0) begin
      e   = q.pop_front();
      v   = ref_imm(e.instr, e.src);
      t64 = 64'(e.pc) + 64'(v);
      chk("imm32", 64'(imm_op), {32'h0, v[31:0]});
      chk("tgt32", 64'(tgt), {32'h0, t64[31:0]});
      chk("ill32", 64'(illegal), 64'(e.src > 3'd4));
      chk("imm64", imm_op64, 64'(v));
      chk("tgt64", tgt64, t64);
      chk("ill64", 64'(illegal64), 64'(e.src > 3'd4));
      n_pop++;
    end
    held = in_valid && !in_ready && !flush;
    if (in_valid && in_ready && !flush) q.push_back('{instr, pc, src});
    if (flush) q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_one(logic [31:0] i, logic [31:0] p, logic [2:0] s);
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    src      = s;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] stall_imm;
    int          p0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; src = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(imm_op), 64'd0);
    chk("rst_tgt", 64'(tgt), 64'd0);
    chk("rst_ill", 64'(illegal), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // I-type, both widths
    out_ready = 1'b1;
    drive_one(32'hFFF00093, 32'h100, 3'b000);
    chk("i_imm", 64'(imm_op), 64'hFFFF_FFFF);
    chk("i_tgt", 64'(tgt), 64'h0000_00FF);
    chk("i_ill", 64'(illegal), 64'd0);
    chk("i_imm64", imm_op64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("i_tgt64", tgt64, 64'h0000_0000_0000_00FF);
    cycle();

    // S and B
    drive_one(32'hFE112C23, 32'h0, 3'b001);
    chk("s_imm", 64'(imm_op), 64'hFFFF_FFF8);
    drive_one(32'hFE000EE3, 32'h100, 3'b010);
    chk("b_imm", 64'(imm_op), 64'hFFFF_FFFC);
    chk("b_tgt", 64'(tgt), 64'h0000_00FC);
    cycle();

    // U and J
    drive_one(32'h123450B7, 32'h0, 3'b011);
    chk("u_imm", 64'(imm_op), 64'h1234_5000);
    drive_one(32'h0080006F, 32'h200, 3'b100);
    chk("j_imm", 64'(imm_op), 64'h0000_0008);
    chk("j_tgt", 64'(tgt), 64'h0000_0208);
    cycle();

    // Illegal format
    drive_one(32'hFFF00093, 32'h40, 3'b111);
    chk("x_imm", 64'(imm_op), 64'd0);
    chk("x_tgt", 64'(tgt), 64'h40);
    chk("x_ill", 64'(illegal), 64'd1);
    cycle();

    // Backpressure: three back-to-back entries with the consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1; src = 3'b000; pc = 32'h1000;
    instr = 32'h00100013; cycle();
    instr = 32'h00200013; cycle();
    instr = 32'h00300013;
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    stall_imm = imm_op;
    chk("bp_head", 64'(stall_imm), 64'd1);
    cycle();
    cycle();
    chk("bp_stable_imm", 64'(imm_op), 64'(stall_imm));
    chk("bp_stable_tgt", 64'(tgt), 64'h1001);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    p0 = n_pop;
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("bp_delivered", 64'(n_pop - p0), 64'd3);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with a new input presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h00400013; cycle();
    instr = 32'h00500013; cycle();
    instr = 32'h7FF00013;
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Flush while ONE: output transfer counts, presented input is dropped
    in_valid = 1'b1; instr = 32'h00600013; cycle();
    instr = 32'h7FF00013; flush = 1'b1;
    p0 = n_pop;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_consumed", 64'(n_pop - p0), 64'd1);
    repeat (2) cycle();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h00700013; cycle();
    instr = 32'h00800013; cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_imm", 64'(imm_op), 64'd0);
    chk("ar_tgt", 64'(tgt), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_imm64", imm_op64, 64'd0);
    q.delete();
    held = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive_one(32'hFFF00093, 32'h100, 3'b000);
    chk("ar_first_imm", 64'(imm_op), 64'hFFFF_FFFF);
    chk("ar_first_tgt", 64'(tgt), 64'hFF);
    cycle();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      if (!held) begin
        in_valid = ($urandom_range(0, 2) != 0);
        instr    = $urandom;
        pc       = $urandom;
        src      = 3'($urandom_range(0, 7));
      end
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    chk("rnd_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. It covers all five RV32 immediate formats (I/S/B/U/J) and sign-extends the immediate to DATA_WIDTH. It also computes the PC-relative target (pc + immediate). Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so downstream stalls never drop instructions.

Parameters:
DATA_WIDTH, 32, width of ImmOp, pc and target; must be >= 32; immediate sign-extended from its format MSB (instr[31]) to DATA_WIDTH.
INSTR_WIDTH, 32, instruction width; fixed at 32; any other value fails elaboration.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline flush, active-high.
in_valid  input  1  instr/pc/ImmSrc valid.
in_ready  output  1  block can accept this cycle.
instr  input  INSTR_WIDTH  instruction from instruction memory.
pc  input  DATA_WIDTH  PC of instr.
ImmSrc  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
out_valid  output  1  ImmOp/target/illegal valid.
out_ready  input  1  downstream accepts.
ImmOp  output  DATA_WIDTH  sign-extended immediate.
target  output  DATA_WIDTH  pc + ImmOp, modulo 2^DATA_WIDTH.
illegal  output  1  ImmSrc was 101-111 for this entry.

Behaviour:
- Reset (rst_n low, async): out_valid=0, ImmOp=0, target=0, illegal=0, both buffer entries invalid, in_ready=1. Reset can arrive mid-operation; all buffered entries are discarded.
- Formats, with s = instr[31] replicated to fill DATA_WIDTH:
  - I = {s, instr[31:20]}.
  - S = {s, instr[31:25], instr[11:7]}.
  - B = {s, instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {s, instr[31:12], 12'b0}.
  - J = {s, instr[19:12], instr[20], instr[30:21], 1'b0}.
- Illegal ImmSrc: ImmOp=0, target=pc, illegal=1. The entry still flows through the handshake normally.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready. The producer holds inputs stable while in_valid & !in_ready.
- Latency: 1 cycle. An input accepted at edge N is visible on the outputs after edge N when the output stage is empty or draining.
- Storage: output register (main) plus skid register.
  - States: EMPTY (neither valid), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & !drain -> FULL (new entry into skid); accept & drain -> ONE (main reloaded); !accept & drain -> EMPTY.
  - FULL: drain -> ONE (skid moves to main, same edge); no accept is possible in FULL.
- in_ready is registered, equal to !skid_valid; it is low only in FULL. It is never combinationally dependent on out_ready.
- Outputs are driven only from the main register. When out_valid & !out_ready, outputs stay stable until the transfer.
- Order: strictly FIFO; no reordering or duplication.
- Flush (synchronous): at the edge, both entries are invalidated, out_valid=0, in_ready=1. An input presented in the flush cycle is dropped even if in_valid & in_ready. An output transfer in the flush cycle still counts as consumed.
- Flush and reset together: reset wins.
- Data registers need no reset beyond the values above. The datapath may be combinational before the main/skid registers.

Test Plan:
- I-type: instr=0xFFF00093, ImmSrc=000, pc=0x0000_0100, out_ready=1 -> one cycle later ImmOp=0xFFFF_FFFF, target=0x0000_00FF, illegal=0.
- S/B formats: S: instr=0xFE112C23 (000) -> ImmOp=0xFFFF_FFF8. Then B: instr=0xFE000EE3 (010) with pc=0x100 -> ImmOp=0xFFFF_FFFC, target=0x0000_00FC.
- U/J formats: U: 0x123450B7 (011) -> ImmOp=0x1234_5000. Then J: 0x0080006F (100) with pc=0x200 -> ImmOp=0x0000_0008, target=0x0000_0208.
- Backpressure: hold out_ready=0 and push 3 back-to-back entries. Required: first 2 accepted, in_ready=0 after the 2nd, 3rd held. Release out_ready -> all 3 delivered in order, no loss or duplicates, outputs stable while stalled.
- Illegal and flush:
  - ImmSrc=111 with pc=0x40 -> ImmOp=0, target=0x40, illegal=1.
  - In FULL state, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input never appears.
- Reset mid-operation: drop rst_n asynchronously while FULL -> out_valid=0 and ImmOp/target=0 immediately. After release, the first new input appears after 1 cycle.
- Parametrised: DATA_WIDTH=64 with the I-type vector -> ImmOp=0xFFFF_FFFF_FFFF_FFFF, target wraps modulo 2^64.
